// File: rtl/logic_unit_pipe.sv
// ---------------------------------------------------------------------------
// logic_unit_pipe
//
// Two-stage pipelined bitwise logic unit with valid/ready handshakes on both
// sides. Each accepted transaction applies one of eight bitwise functions to
// two WIDTH-bit operands. The result leaves with zero and parity flags. A
// counter tracks how many results the consumer has taken.
//
// Ports:
//   i_clk     rising-edge clock
//   i_rst_n   asynchronous active-low reset
//   i_valid   upstream transaction valid
//   o_ready   block can accept a transaction this cycle (combinational)
//   i_op      opcode: 0 NOT a, 1 AND, 2 OR, 3 NAND, 4 NOR, 5 XOR, 6 XNOR, 7 PASS a
//   i_a       operand A
//   i_b       operand B (ignored for NOT and PASS)
//   o_valid   result valid
//   i_ready   downstream accepts result
//   o_y       result
//   o_zero    o_y == 0
//   o_parity  XOR-reduction of o_y
//   o_count   number of results accepted downstream (wraps)
// ---------------------------------------------------------------------------
module logic_unit_pipe #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [2:0]       i_op,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_y,
    output logic             o_zero,
    output logic             o_parity,
    output logic [CNT_W-1:0] o_count
);

    logic             v1;
    logic             v2;
    logic [2:0]       op1;
    logic [WIDTH-1:0] a1;
    logic [WIDTH-1:0] b1;
    logic             adv1;
    logic             adv2;
    logic [WIDTH-1:0] f;

    // Stage 2 can take new content when it is empty or its result is leaving.
    // Stage 1 can take new content when it is empty or it is moving forward.
    assign adv2    = !v2 || i_ready;
    assign adv1    = !v1 || adv2;
    assign o_ready = adv1;
    assign o_valid = v2;

    always_comb begin
        f = '0;
        case (op1)
            3'd0: f = ~a1;
            3'd1: f = a1 & b1;
            3'd2: f = a1 | b1;
            3'd3: f = ~(a1 & b1);
            3'd4: f = ~(a1 | b1);
            3'd5: f = a1 ^ b1;
            3'd6: f = ~(a1 ^ b1);
            3'd7: f = a1;
        endcase
    end

    // Capture stage. When stage 1 moves on without a new transfer it becomes
    // a bubble; operand registers only load on a real transfer so idle inputs
    // never disturb its contents.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            v1  <= 1'b0;
            op1 <= '0;
            a1  <= '0;
            b1  <= '0;
        end else if (adv1) begin
            v1 <= i_valid;
            if (i_valid) begin
                op1 <= i_op;
                a1  <= i_a;
                b1  <= i_b;
            end
        end
    end

    // Output stage. Flags come from the freshly computed function, so they
    // always describe the value being loaded rather than the previous o_y.
    // Bubbles leave o_y untouched to keep the result bus quiet while idle.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            v2       <= 1'b0;
            o_y      <= '0;
            o_zero   <= 1'b0;
            o_parity <= 1'b0;
        end else if (adv2) begin
            v2 <= v1;
            if (v1) begin
                o_y      <= f;
                o_zero   <= (f == '0);
                o_parity <= ^f;
            end
        end
    end

    // Completed-transaction counter; wraps naturally at 2^CNT_W.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_count <= '0;
        end else if (v2 && i_ready) begin
            o_count <= o_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_logic_unit_pipe.sv
// ---------------------------------------------------------------------------
// tb_logic_unit_pipe
//
// Drives logic_unit_pipe (WIDTH=8, CNT_W=4) through directed and random
// valid/ready traffic. A queue holds the transactions in flight. Each entry
// records the expected result and the edge on which it was accepted. An entry
// is visible at the output once at least one further edge has passed.
// ---------------------------------------------------------------------------
module tb_logic_unit_pipe;

    logic       i_clk;
    logic       i_rst_n;
    logic       i_valid;
    logic       o_ready;
    logic [2:0] i_op;
    logic [7:0] i_a;
    logic [7:0] i_b;
    logic       o_valid;
    logic       i_ready;
    logic [7:0] o_y;
    logic       o_zero;
    logic       o_parity;
    logic [3:0] o_count;

    logic_unit_pipe #(.WIDTH(8), .CNT_W(4)) dut (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .i_valid  (i_valid),
        .o_ready  (o_ready),
        .i_op     (i_op),
        .i_a      (i_a),
        .i_b      (i_b),
        .o_valid  (o_valid),
        .i_ready  (i_ready),
        .o_y      (o_y),
        .o_zero   (o_zero),
        .o_parity (o_parity),
        .o_count  (o_count)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    typedef struct {
        logic [7:0] y;
        int         acc;
    } item_t;

    item_t      q[$];
    logic [7:0] log_y[$];
    logic       log_z[$];
    logic       log_p[$];
    int         edge_cnt;
    int         cnt;
    int         total;
    int         bad;

    function automatic logic [7:0] ref_f(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        case (op)
            3'd0:    return ~a;
            3'd1:    return a & b;
            3'd2:    return a | b;
            3'd3:    return ~(a & b);
            3'd4:    return ~(a | b);
            3'd5:    return a ^ b;
            3'd6:    return ~(a ^ b);
            default: return a;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock of traffic. Outputs are checked at the falling edge; the model
    // is updated at the rising edge; inputs change 1 time unit after it.
    task automatic cycle(input logic v, input logic [2:0] op, input logic [7:0] a,
                         input logic [7:0] b, input logic rdy, output logic took);
        logic       exp_valid;
        logic       exp_ready;
        logic       pop;
        logic       push;
        logic [7:0] ey;
        item_t      it;
        i_valid = v;
        i_op    = op;
        i_a     = a;
        i_b     = b;
        i_ready = rdy;
        @(negedge i_clk);
        exp_valid = (q.size() > 0) && (edge_cnt > q[0].acc);
        exp_ready = (q.size() < 2) || rdy;
        chk("o_valid", {31'd0, o_valid}, {31'd0, exp_valid});
        chk("o_ready", {31'd0, o_ready}, {31'd0, exp_ready});
        chk("o_count", {28'd0, o_count}, cnt);
        if (exp_valid) begin
            ey = q[0].y;
            chk("o_y", {24'd0, o_y}, {24'd0, ey});
            chk("o_zero", {31'd0, o_zero}, {31'd0, (ey == 8'd0)});
            chk("o_parity", {31'd0, o_parity}, $countones(ey) % 2);
        end
        pop  = exp_valid && rdy;
        push = v && exp_ready;
        if (pop) begin
            log_y.push_back(o_y);
            log_z.push_back(o_zero);
            log_p.push_back(o_parity);
        end
        @(posedge i_clk);
        edge_cnt++;
        if (pop) begin
            void'(q.pop_front());
            cnt = (cnt + 1) % 16;
        end
        if (push) begin
            it.y   = ref_f(op, a, b);
            it.acc = edge_cnt;
            q.push_back(it);
        end
        took = push;
        #1;
    endtask

    task automatic idle(input logic rdy);
        logic t;
        cycle(1'b0, 3'($urandom), 8'($urandom), 8'($urandom), rdy, t);
    endtask

    // Asynchronous reset between clock edges; outputs must clear at once.
    task automatic applyReset();
        i_valid = 1'b0;
        i_ready = 1'b0;
        #2;
        i_rst_n = 1'b0;
        #1;
        chk("rst_o_valid", {31'd0, o_valid}, 32'd0);
        chk("rst_o_y", {24'd0, o_y}, 32'd0);
        chk("rst_o_count", {28'd0, o_count}, 32'd0);
        chk("rst_o_ready", {31'd0, o_ready}, 32'd1);
        q.delete();
        cnt = 0;
        log_y.delete();
        log_z.delete();
        log_p.delete();
        @(negedge i_clk);
        i_rst_n = 1'b1;
        @(posedge i_clk);
        edge_cnt++;
        #1;
    endtask

    initial begin
        logic [7:0] sweep_exp[8];
        logic       t;
        int         pend;
        int         guard;

        total    = 0;
        bad      = 0;
        cnt      = 0;
        edge_cnt = 0;
        i_rst_n  = 1'b1;
        i_valid  = 1'b0;
        i_ready  = 1'b0;
        i_op     = 3'd0;
        i_a      = 8'd0;
        i_b      = 8'd0;
        #1;
        applyReset();

        // Opcode sweep with A5 / 0F, back-to-back.
        sweep_exp = '{8'h5A, 8'h05, 8'hAF, 8'hFA, 8'h50, 8'hAA, 8'h55, 8'hA5};
        for (int op = 0; op < 8; op++) cycle(1'b1, 3'(op), 8'hA5, 8'h0F, 1'b1, t);
        for (int k = 0; k < 3; k++) idle(1'b1);
        chk("sweep_len", log_y.size(), 32'd8);
        for (int k = 0; k < 8 && k < log_y.size(); k++) begin
            chk("sweep_y", {24'd0, log_y[k]}, {24'd0, sweep_exp[k]});
            chk("sweep_par", {31'd0, log_p[k]}, 32'd0);
        end
        chk("sweep_count", {28'd0, o_count}, 32'd8);

        // Flag corner cases.
        log_y.delete();
        log_z.delete();
        log_p.delete();
        cycle(1'b1, 3'd1, 8'hF0, 8'h0F, 1'b1, t);
        cycle(1'b1, 3'd5, 8'hF0, 8'h0F, 1'b1, t);
        cycle(1'b1, 3'd0, 8'hFE, 8'h00, 1'b1, t);
        for (int k = 0; k < 3; k++) idle(1'b1);
        chk("flags_len", log_y.size(), 32'd3);
        if (log_y.size() == 3) begin
            chk("and_y", {24'd0, log_y[0]}, 32'h00);
            chk("and_zero", {31'd0, log_z[0]}, 32'd1);
            chk("and_par", {31'd0, log_p[0]}, 32'd0);
            chk("xor_y", {24'd0, log_y[1]}, 32'hFF);
            chk("xor_zero", {31'd0, log_z[1]}, 32'd0);
            chk("xor_par", {31'd0, log_p[1]}, 32'd0);
            chk("not_y", {24'd0, log_y[2]}, 32'h01);
            chk("not_par", {31'd0, log_p[2]}, 32'd1);
        end

        // Backpressure: four transactions with the consumer stalled 5 cycles.
        applyReset();
        pend = 0;
        for (int c = 0; c < 5; c++) begin
            cycle(1'b1, 3'd5, 8'(pend * 8'h11), 8'h0F, 1'b0, t);
            if (t) pend++;
        end
        chk("stall_ready_low", {31'd0, o_ready}, 32'd0);
        chk("stall_hold_y", {24'd0, o_y}, 32'h0F);
        guard = 0;
        while ((pend < 4 || q.size() > 0) && guard < 40) begin
            if (pend < 4) begin
                cycle(1'b1, 3'd5, 8'(pend * 8'h11), 8'h0F, 1'b1, t);
                if (t) pend++;
            end else begin
                idle(1'b1);
            end
            guard++;
        end
        chk("stall_drained", {31'd0, (guard < 40)}, 32'd1);
        chk("stall_count", {28'd0, o_count}, 32'd4);
        chk("stall_len", log_y.size(), 32'd4);

        // Full pipeline, producer and consumer active together: no bubble.
        applyReset();
        cycle(1'b1, 3'd2, 8'h01, 8'h02, 1'b0, t);
        cycle(1'b1, 3'd2, 8'h04, 8'h08, 1'b0, t);
        for (int c = 0; c < 4; c++) begin
            cycle(1'b1, 3'd6, 8'(c), 8'h3C, 1'b1, t);
            chk("shift_no_bubble", {31'd0, o_valid}, 32'd1);
        end
        for (int k = 0; k < 3; k++) idle(1'b1);

        // Counter wrap: 17 results on a 4-bit counter ends at 1.
        applyReset();
        for (int c = 0; c < 17; c++) cycle(1'b1, 3'd7, 8'(c), 8'h00, 1'b1, t);
        for (int k = 0; k < 3; k++) idle(1'b1);
        chk("wrap_count", {28'd0, o_count}, 32'd1);

        // Random traffic against the queue model.
        applyReset();
        for (int c = 0; c < 400; c++) begin
            cycle(1'($urandom), 3'($urandom), 8'($urandom), 8'($urandom),
                  ($urandom_range(0, 3) != 0), t);
        end

        // Fill both stages, then reset mid-stream.
        cycle(1'b1, 3'd1, 8'h3C, 8'hFF, 1'b0, t);
        cycle(1'b1, 3'd1, 8'h3C, 8'hFF, 1'b0, t);
        cycle(1'b1, 3'd1, 8'h3C, 8'hFF, 1'b0, t);
        applyReset();
        for (int k = 0; k < 4; k++) idle(1'b1);
        chk("post_rst_count", {28'd0, o_count}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
